// File: rtl/ifetch_pkg.sv
// Shared constants and types for the prefetching instruction-fetch stage.
package ifetch_pkg;

    localparam int unsigned PC_INC   = 4;
    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned ILEN_DEF = 32;

    // Layout of one queue entry; the top packs {pc, inst} in this order.
    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic [ILEN_DEF-1:0] inst;
    } fetch_entry_t;

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Synchronous FIFO with flush; head entry is read straight from storage.
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CW   = cnt_width(DEPTH),
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CW-1:0]    count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Storage is reset too so the head reads as zero out of reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/ifetch_buffer.sv
// Fetch stage: PC generation, in-order memory requests, prefetch queue to decode.
module ifetch_buffer
    import ifetch_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     ILEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    output logic            req_valid_o,
    input  logic            req_ready_i,
    output logic [XLEN-1:0] req_addr_o,
    input  logic            rsp_valid_i,
    input  logic [ILEN-1:0] rsp_data_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            inst_valid_o,
    input  logic            inst_ready_i,
    output logic [ILEN-1:0] inst_o,
    output logic [XLEN-1:0] inst_pc_o
);

    localparam int unsigned     CW         = cnt_width(DEPTH);
    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};
    localparam logic [XLEN-1:0] INC        = XLEN'(PC_INC);
    localparam logic [CW:0]     DEPTH_W    = (CW+1)'(DEPTH);

    logic [XLEN-1:0]      pc_q, pc_d, rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]        out_cnt_q, out_cnt_d, drop_cnt_q, drop_cnt_d;
    logic [CW-1:0]        fifo_count;
    logic                 fifo_full, fifo_empty;
    logic [XLEN+ILEN-1:0] fifo_rdata;
    logic                 credit_ok, req_fire, rsp_keep, inst_pop;

    // Both valid/ready pairs transfer on a cycle where valid and ready are high;
    // valid never depends on ready. Credit ignores a same-cycle pop on purpose.
    assign credit_ok    = ({1'b0, fifo_count} + {1'b0, out_cnt_q}) < DEPTH_W;
    assign req_valid_o  = !rst_i && !redirect_i && credit_ok;
    assign req_addr_o   = pc_q;
    assign req_fire     = req_valid_o && req_ready_i;

    assign inst_valid_o = !fifo_empty && !redirect_i;
    assign inst_pop     = inst_valid_o && inst_ready_i;
    assign {inst_pc_o, inst_o} = fifo_rdata;

    assign rsp_keep     = rsp_valid_i && !redirect_i && (drop_cnt_q == '0);

    ifetch_fifo #(
        .WIDTH (XLEN + ILEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (redirect_i),
        .push_i  (rsp_keep),
        .wdata_i ({rsp_pc_q, rsp_data_i}),
        .pop_i   (inst_pop),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        pc_d       = pc_q;
        rsp_pc_d   = rsp_pc_q;
        out_cnt_d  = out_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (redirect_i) begin
            // Everything still in flight belongs to the old stream.
            pc_d       = redirect_pc_i & ALIGN_MASK;
            rsp_pc_d   = redirect_pc_i & ALIGN_MASK;
            out_cnt_d  = out_cnt_q - CW'(rsp_valid_i);
            drop_cnt_d = out_cnt_q - CW'(rsp_valid_i);
        end else begin
            if (req_fire) pc_d = pc_q + INC;
            out_cnt_d = out_cnt_q + CW'(req_fire) - CW'(rsp_valid_i);
            if (rsp_valid_i) begin
                if (drop_cnt_q != '0) drop_cnt_d = drop_cnt_q - CW'(1);
                else                  rsp_pc_d   = rsp_pc_q + INC;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q       <= RESET_PC & ALIGN_MASK;
            rsp_pc_q   <= RESET_PC & ALIGN_MASK;
            out_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            pc_q       <= pc_d;
            rsp_pc_q   <= rsp_pc_d;
            out_cnt_q  <= out_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    no_overflow_a: assert property (@(posedge clk_i) disable iff (rst_i)
        !(rsp_keep && fifo_full));

endmodule

// File: tb/tb_ifetch_buffer.sv
// Bench for ifetch_buffer: memory model with variable latency, stream-level reference model.
module tb_ifetch_buffer;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_o, req_ready_i = 1'b0;
    logic [31:0] req_addr_o;
    logic        rsp_valid_i = 1'b0;
    logic [31:0] rsp_data_i = '0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        inst_valid_o, inst_ready_i = 1'b0;
    logic [31:0] inst_o, inst_pc_o;

    ifetch_buffer #(
        .XLEN     (32),
        .ILEN     (32),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .req_valid_o   (req_valid_o),
        .req_ready_i   (req_ready_i),
        .req_addr_o    (req_addr_o),
        .rsp_valid_i   (rsp_valid_i),
        .rsp_data_i    (rsp_data_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .inst_valid_o  (inst_valid_o),
        .inst_ready_i  (inst_ready_i),
        .inst_o        (inst_o),
        .inst_pc_o     (inst_pc_o)
    );

    // ---------------- clock ----------------
    always #5 clk_i = ~clk_i;

    // ---------------- reference model state ----------------
    typedef struct {
        logic [31:0] addr;
        int          due;
        int          ep;
    } mreq_t;

    mreq_t       mem_q[$];     // requests accepted by memory, in order
    logic [31:0] exp_q[$];     // PCs expected in the queue toward decode
    logic [31:0] next_addr = RESET_PC;
    int          epoch = 0;
    int          cyc = 0;
    int          last_due = 0;
    int          lat_lo = 1, lat_hi = 1;
    int          checks = 0, errors = 0;

    // samples of the DUT taken in the last cycle
    logic        s_req_valid, s_inst_valid;
    logic [31:0] s_req_addr, s_inst_pc;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: present memory response, check outputs, advance the model.
    task automatic cycle();
        logic  has_rsp, exp_rv, exp_iv, fire, pop;
        mreq_t m;
        int    due, lat;
        has_rsp     = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        rsp_valid_i = has_rsp;
        rsp_data_i  = has_rsp ? mem_fn(mem_q[0].addr) : $urandom;
        #1;
        exp_rv = !redirect_i && ((exp_q.size() + mem_q.size()) < DEPTH);
        exp_iv = !redirect_i && (exp_q.size() != 0);
        chk("req_valid", req_valid_o, exp_rv);
        if (exp_rv) chk("req_addr", req_addr_o, next_addr);
        chk("inst_valid", inst_valid_o, exp_iv);
        if (exp_iv) begin
            chk("inst_pc", inst_pc_o, exp_q[0]);
            chk("inst", inst_o, mem_fn(exp_q[0]));
        end
        fire = exp_rv && req_ready_i;
        pop  = exp_iv && inst_ready_i;
        s_req_valid  = req_valid_o;
        s_req_addr   = req_addr_o;
        s_inst_valid = inst_valid_o;
        s_inst_pc    = inst_pc_o;
        @(posedge clk_i);
        if (has_rsp) m = mem_q.pop_front();
        if (redirect_i) begin
            exp_q.delete();
            epoch++;
            next_addr = redirect_pc_i & ~32'h3;
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (has_rsp && m.ep == epoch) exp_q.push_back(m.addr);
            if (fire) begin
                lat = $urandom_range(lat_hi, lat_lo);
                due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
                mem_q.push_back('{next_addr, due, epoch});
                last_due  = due;
                next_addr = next_addr + 32'd4;
            end
        end
        cyc++;
        @(negedge clk_i);
    endtask

    // Reset is raised between edges, so the outputs must drop asynchronously.
    task automatic do_reset();
        rst_i       = 1'b1;
        rsp_valid_i = 1'b0;
        redirect_i  = 1'b0;
        #1;
        chk("rst_req_valid", req_valid_o, 1'b0);
        chk("rst_inst_valid", inst_valid_o, 1'b0);
        chk("rst_req_addr", req_addr_o, RESET_PC);
        chk("rst_inst", inst_o, 32'h0);
        chk("rst_inst_pc", inst_pc_o, 32'h0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        mem_q.delete();
        exp_q.delete();
        next_addr = RESET_PC;
        last_due  = cyc;
    endtask

    task automatic drain();
        req_ready_i  = 1'b0;
        inst_ready_i = 1'b1;
        redirect_i   = 1'b0;
        repeat (12) cycle();
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [31:0] target;
        logic [31:0] exp_addr0;
        logic [31:0] exp_addr1;
    } redir_vec_t;

    redir_vec_t  vecs[5];
    logic [31:0] bp_pcs[5];

    initial begin
        int fires, got, idx;
        logic found;

        vecs[0] = '{32'h0000_0203, 32'h0000_0200, 32'h0000_0204};
        vecs[1] = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000};
        vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0000_0000};
        vecs[3] = '{32'h0000_1001, 32'h0000_1000, 32'h0000_1004};
        vecs[4] = '{32'h0000_0042, 32'h0000_0040, 32'h0000_0044};
        bp_pcs  = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};

        @(negedge clk_i);
        do_reset();

        // Latency 1, decode always ready: back-to-back requests and deliveries.
        lat_lo = 1; lat_hi = 1;
        req_ready_i = 1'b1; inst_ready_i = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cycle();
            chk("stream_req_valid", s_req_valid, 1'b1);
            if (i >= 2) chk("stream_inst_valid", s_inst_valid, 1'b1);
        end

        // Decode stalled for 20 cycles at latency 2.
        @(negedge clk_i);
        #2;
        do_reset();
        lat_lo = 2; lat_hi = 2;
        req_ready_i = 1'b1; inst_ready_i = 1'b0;
        fires = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (s_req_valid) fires++;
        end
        chk("bp_fires", fires, 4);
        chk("bp_req_valid_end", s_req_valid, 1'b0);
        chk("bp_head_pc", s_inst_pc, 32'h0);
        inst_ready_i = 1'b1;
        got = 0;
        for (int i = 0; i < 30 && got < 5; i++) begin
            cycle();
            if (s_inst_valid) begin
                chk("bp_order", s_inst_pc, bp_pcs[got]);
                got++;
            end
        end
        chk("bp_delivered", got, 5);

        // Redirect targets: alignment and address wrap.
        lat_lo = 1; lat_hi = 1;
        foreach (vecs[k]) begin
            drain();
            req_ready_i   = 1'b1;
            redirect_i    = 1'b1;
            redirect_pc_i = vecs[k].target;
            cycle();
            redirect_i = 1'b0;
            cycle();
            chk("redir_addr0_valid", s_req_valid, 1'b1);
            chk("redir_addr0", s_req_addr, vecs[k].exp_addr0);
            cycle();
            chk("redir_addr1", s_req_addr, vecs[k].exp_addr1);
            found = 1'b0;
            for (int i = 0; i < 20 && !found; i++) begin
                cycle();
                if (s_inst_valid) begin
                    found = 1'b1;
                    chk("redir_first_pc", s_inst_pc, vecs[k].exp_addr0);
                end
            end
            chk("redir_first_seen", found, 1'b1);
        end

        // Latency 3: redirect with three requests in flight, one answering now.
        drain();
        lat_lo = 3; lat_hi = 3;
        req_ready_i   = 1'b1;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h40;
        cycle();
        redirect_i = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (mem_q.size() == 3 && mem_q[0].due <= cyc) begin
                found         = 1'b1;
                redirect_i    = 1'b1;
                redirect_pc_i = 32'h100;
            end
            cycle();
            redirect_i = 1'b0;
        end
        chk("l3_redirect_point", found, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            cycle();
            if (s_inst_valid) begin
                found = 1'b1;
                chk("l3_first_pc", s_inst_pc, 32'h100);
            end
        end
        chk("l3_first_seen", found, 1'b1);

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            if (i % 250 == 0) begin
                lat_lo = $urandom_range(3, 1);
                lat_hi = $urandom_range(5, lat_lo);
            end
            req_ready_i   = ($urandom_range(3, 0) != 0);
            inst_ready_i  = ($urandom_range(3, 0) != 0);
            redirect_i    = ($urandom_range(29, 0) == 0);
            redirect_pc_i = $urandom;
            cycle();
        end

        // Reset in the middle of a stream with three queued entries.
        drain();
        lat_lo = 1; lat_hi = 1;
        req_ready_i = 1'b1; inst_ready_i = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            if (exp_q.size() == 3) found = 1'b1;
        end
        chk("fill3_reached", found, 1'b1);
        chk("pre_rst_inst_valid", inst_valid_o, 1'b1);
        #3;
        do_reset();
        cycle();
        chk("restart_req_valid", s_req_valid, 1'b1);
        chk("restart_addr", s_req_addr, RESET_PC);
        chk("restart_empty", s_inst_valid, 1'b0);
        inst_ready_i = 1'b1;
        idx = 0;
        for (int i = 0; i < 10; i++) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard time limit so the bench always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

endmodule
